// File: rtl/dma_page_pkg.sv
// Shared types and helpers for the DMA page address latch.
// Holds the CPU index <-> DMA channel mapping of the XT page-register ports
// (0x80 -> ch0, 0x81 -> ch2, 0x82 -> ch3, 0x83 -> ch1) and small decode helpers.
package dma_page_pkg;

  localparam int PAGE_WIDTH_XT = 4;

  typedef logic [1:0] dma_channel_t;

  // CPU port index (address_in) to DMA channel number
  function automatic dma_channel_t index_to_channel(input logic [1:0] idx);
    dma_channel_t ch;
    case (idx)
      2'd0:    ch = 2'd0;
      2'd1:    ch = 2'd2;
      2'd2:    ch = 2'd3;
      default: ch = 2'd1;
    endcase
    return ch;
  endfunction

  // DMA channel number back to CPU port index
  function automatic logic [1:0] channel_to_index(input dma_channel_t ch);
    logic [1:0] idx;
    case (ch)
      2'd0:    idx = 2'd0;
      2'd2:    idx = 2'd1;
      2'd3:    idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // True when exactly one DACK line is active
  function automatic logic dack_is_one_hot(input logic [3:0] dack);
    return (dack != 4'b0000) && ((dack & (dack - 4'd1)) == 4'b0000);
  endfunction

  // True when two or more DACK lines are active
  function automatic logic dack_is_multi(input logic [3:0] dack);
    return (dack & (dack - 4'd1)) != 4'b0000;
  endfunction

  // One-hot DACK to channel number; only meaningful when dack_is_one_hot
  function automatic dma_channel_t onehot_to_channel(input logic [3:0] dack);
    dma_channel_t ch;
    case (dack)
      4'b0010: ch = 2'd1;
      4'b0100: ch = 2'd2;
      4'b1000: ch = 2'd3;
      default: ch = 2'd0;
    endcase
    return ch;
  endfunction

  // 64K boundary crossing seen on consecutive high bytes, in either direction
  function automatic logic is_page_wrap(input logic [7:0] prev_hi,
                                        input logic [7:0] new_hi);
    return ((prev_hi == 8'hFF) && (new_hi == 8'h00)) ||
           ((prev_hi == 8'h00) && (new_hi == 8'hFF));
  endfunction

endpackage

// File: rtl/dma_page_register_file.sv
// Four per-channel page registers: one synchronous write port and two
// asynchronous read ports (DMA address assembly and CPU read-back).
module dma_page_register_file
  import dma_page_pkg::*;
#(
  parameter int PAGE_WIDTH = PAGE_WIDTH_XT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  dma_channel_t          write_channel,
  input  logic [PAGE_WIDTH-1:0] write_data,
  input  dma_channel_t          dma_channel,
  output logic [PAGE_WIDTH-1:0] dma_page,
  input  dma_channel_t          cpu_channel,
  output logic [PAGE_WIDTH-1:0] cpu_page
);

  logic [PAGE_WIDTH-1:0] page_q [4];
  logic [PAGE_WIDTH-1:0] page_d [4];

  // Next-state of the register array: single write port
  always_comb begin
    page_d = page_q;
    if (write_enable) begin
      page_d[write_channel] = write_data;
    end
  end

  // Page storage, cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page_q <= '{default: '0};
    end else begin
      page_q <= page_d;
    end
  end

  assign dma_page = page_q[dma_channel];
  assign cpu_page = page_q[cpu_channel];

endmodule

// File: rtl/dma_page_address_latch.sv
// System DMA address assembly for an 8237: page register, strobed high byte
// and controller low byte, plus 64K page-wrap detection per channel.
// Optional build macro: DMA_PAGE_READBACK_EN enables CPU read-back of the
// page registers on data_bus_out; otherwise the port reads as 8'h00.
module dma_page_address_latch
  import dma_page_pkg::*;
#(
  parameter int PAGE_WIDTH = PAGE_WIDTH_XT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     chip_select_n,
  input  logic                     io_write_n,
  input  logic                     io_read_n,
  input  logic [1:0]               address_in,
  input  logic [7:0]               data_bus_in,
  output logic [7:0]               data_bus_out,
  input  logic [7:0]               dma_data_bus,
  input  logic [7:0]               dma_address_low,
  input  logic                     address_strobe,
  input  logic                     address_enable,
  input  logic [3:0]               dma_acknowledge,
  output logic [16+PAGE_WIDTH-1:0] dma_address,
  output logic                     dma_address_valid,
  output logic                     page_wrap_pulse,
  output logic [3:0]               page_wrap_status,
  output logic                     dack_conflict
);

  localparam int ADDR_W = 16 + PAGE_WIDTH;

  // CPU write capture
  logic                  wr_n_q;
  logic                  wr_pend_q,  wr_pend_d;
  dma_channel_t          wr_ch_q,    wr_ch_d;
  logic [PAGE_WIDTH-1:0] wr_data_q,  wr_data_d;
  logic                  commit;

  // DMA side state
  logic [7:0]            hi_q,       hi_d;
  dma_channel_t          sel_q,      sel_d;
  logic                  stb_q;
  logic [7:0]            prev_hi_q,  prev_hi_d;
  dma_channel_t          prev_ch_q,  prev_ch_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [3:0]            status_q,   status_d;
  logic                  pulse_q,    pulse_d;
  logic [ADDR_W-1:0]     addr_q,     addr_d;

  logic                  dack_one_hot;
  logic                  valid_int;
  logic                  strobe_fall;
  logic                  wrap_hit;
  logic [PAGE_WIDTH-1:0] dma_page;
  logic [PAGE_WIDTH-1:0] cpu_page;

  // Only the low PAGE_WIDTH bits of the CPU data are stored
  logic unused_data_bus;
  assign unused_data_bus = ^data_bus_in;

  assign dack_one_hot = dack_is_one_hot(dma_acknowledge);
  assign valid_int    = address_enable & dack_one_hot;

  // A write lands on the first clock that sees io_write_n high again
  assign commit = wr_pend_q & io_write_n & ~wr_n_q;

  dma_page_register_file #(
    .PAGE_WIDTH (PAGE_WIDTH)
  ) u_page_regs (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (commit),
    .write_channel (wr_ch_q),
    .write_data    (wr_data_q),
    .dma_channel   (sel_d),
    .dma_page      (dma_page),
    .cpu_channel   (index_to_channel(address_in)),
    .cpu_page      (cpu_page)
  );

  // CPU write capture: data and index tracked while the write strobe is low
  always_comb begin
    wr_pend_d = wr_pend_q;
    wr_ch_d   = wr_ch_q;
    wr_data_d = wr_data_q;
    if (commit) begin
      wr_pend_d = 1'b0;
    end
    if (!chip_select_n && !io_write_n) begin
      wr_pend_d = 1'b1;
      wr_ch_d   = index_to_channel(address_in);
      wr_data_d = data_bus_in[PAGE_WIDTH-1:0];
    end
  end

  // DMA datapath: high-byte latch, channel select, address and wrap tracking
  always_comb begin
    hi_d       = address_strobe ? dma_data_bus : hi_q;
    sel_d      = dack_one_hot ? onehot_to_channel(dma_acknowledge) : sel_q;
    addr_d     = valid_int ? {dma_page, hi_q, dma_address_low} : addr_q;

    // Wrap check compares against the previous high byte only when it came
    // from the same channel; a new channel (or a fresh reset) just reloads.
    strobe_fall = stb_q & ~address_strobe & valid_int;
    wrap_hit    = strobe_fall & prev_vld_q & (prev_ch_q == sel_d) &
                  is_page_wrap(prev_hi_q, hi_q);

    prev_hi_d  = prev_hi_q;
    prev_ch_d  = prev_ch_q;
    prev_vld_d = prev_vld_q;
    if (strobe_fall) begin
      prev_hi_d  = hi_q;
      prev_ch_d  = sel_d;
      prev_vld_d = 1'b1;
    end

    // Commit clears the channel flag; a coincident wrap set overrides it
    status_d = status_q;
    if (commit) begin
      status_d[wr_ch_q] = 1'b0;
    end
    if (wrap_hit) begin
      status_d[sel_d] = 1'b1;
    end
    pulse_d = wrap_hit;
  end

  // State registers; everything returns to zero on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_n_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_ch_q    <= '0;
      wr_data_q  <= '0;
      hi_q       <= '0;
      sel_q      <= '0;
      stb_q      <= 1'b0;
      prev_hi_q  <= '0;
      prev_ch_q  <= '0;
      prev_vld_q <= 1'b0;
      status_q   <= '0;
      pulse_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      wr_n_q     <= io_write_n;
      wr_pend_q  <= wr_pend_d;
      wr_ch_q    <= wr_ch_d;
      wr_data_q  <= wr_data_d;
      hi_q       <= hi_d;
      sel_q      <= sel_d;
      stb_q      <= address_strobe;
      prev_hi_q  <= prev_hi_d;
      prev_ch_q  <= prev_ch_d;
      prev_vld_q <= prev_vld_d;
      status_q   <= status_d;
      pulse_q    <= pulse_d;
      addr_q     <= addr_d;
    end
  end

  // Combinational status outputs are forced low while reset is held
  assign dma_address_valid = ~reset & valid_int;
  assign dack_conflict     = ~reset & address_enable & dack_is_multi(dma_acknowledge);
  assign dma_address       = addr_q;
  assign page_wrap_pulse   = pulse_q;
  assign page_wrap_status  = status_q;

`ifdef DMA_PAGE_READBACK_EN
  assign data_bus_out = (!reset && !chip_select_n && !io_read_n) ? 8'(cpu_page) : 8'h00;
`else
  logic unused_readback;
  assign unused_readback = ^{io_read_n, cpu_page};
  assign data_bus_out    = 8'h00;
`endif

endmodule

// File: tb/tb_dma_page_address_latch.sv
// Directed bench for dma_page_address_latch (default PAGE_WIDTH = 4).
module tb_dma_page_address_latch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        chip_select_n;
  logic        io_write_n;
  logic        io_read_n;
  logic [1:0]  address_in;
  logic [7:0]  data_bus_in;
  logic [7:0]  data_bus_out;
  logic [7:0]  dma_data_bus;
  logic [7:0]  dma_address_low;
  logic        address_strobe;
  logic        address_enable;
  logic [3:0]  dma_acknowledge;
  logic [19:0] dma_address;
  logic        dma_address_valid;
  logic        page_wrap_pulse;
  logic [3:0]  page_wrap_status;
  logic        dack_conflict;

  int checks = 0;
  int errors = 0;

  dma_page_address_latch dut (
    .clock             (clock),
    .reset             (reset),
    .chip_select_n     (chip_select_n),
    .io_write_n        (io_write_n),
    .io_read_n         (io_read_n),
    .address_in        (address_in),
    .data_bus_in       (data_bus_in),
    .data_bus_out      (data_bus_out),
    .dma_data_bus      (dma_data_bus),
    .dma_address_low   (dma_address_low),
    .address_strobe    (address_strobe),
    .address_enable    (address_enable),
    .dma_acknowledge   (dma_acknowledge),
    .dma_address       (dma_address),
    .dma_address_valid (dma_address_valid),
    .page_wrap_pulse   (page_wrap_pulse),
    .page_wrap_status  (page_wrap_status),
    .dack_conflict     (dack_conflict)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic page_write(input logic [1:0] idx, input logic [7:0] data);
    address_in    = idx;
    data_bus_in   = data;
    chip_select_n = 1'b0;
    io_write_n    = 1'b0;
    tick();
    io_write_n    = 1'b1;
    chip_select_n = 1'b1;
    tick();
  endtask

  // One strobe of the high byte: latched on the first clock, falling edge seen on the next
  task automatic strobe_hi(input logic [7:0] hi);
    dma_data_bus   = hi;
    address_strobe = 1'b1;
    tick();
    address_strobe = 1'b0;
    tick();
  endtask

  initial begin
    chip_select_n   = 1'b1;
    io_write_n      = 1'b1;
    io_read_n       = 1'b1;
    address_in      = 2'd0;
    data_bus_in     = 8'h00;
    dma_data_bus    = 8'h00;
    dma_address_low = 8'h00;
    address_strobe  = 1'b0;
    address_enable  = 1'b0;
    dma_acknowledge = 4'b0000;
    reset           = 1'b1;
    tick();
    tick();
    check("reset_addr",     dma_address,       32'h0);
    check("reset_valid",    dma_address_valid, 32'h0);
    check("reset_pulse",    page_wrap_pulse,   32'h0);
    check("reset_status",   page_wrap_status,  32'h0);
    check("reset_conflict", dack_conflict,     32'h0);
    check("reset_dbo",      data_bus_out,      32'h0);
    reset = 1'b0;
    tick();

    // Page writes and first DMA address on channel 1
    page_write(2'd3, 8'h05);
    page_write(2'd1, 8'h0A);
    page_write(2'd2, 8'h03);
    page_write(2'd0, 8'h0C);
    dma_acknowledge = 4'b0010;
    address_enable  = 1'b1;
    dma_address_low = 8'h34;
    strobe_hi(8'h12);
    check("t1_addr",  dma_address,       32'h51234);
    check("t1_valid", dma_address_valid, 32'h1);
    check("t1_pulse", page_wrap_pulse,   32'h0);

    // Increment wrap on channel 2
    dma_acknowledge = 4'b0100;
    strobe_hi(8'hFF);
    check("t2_reload_pulse", page_wrap_pulse, 32'h0);
    strobe_hi(8'h00);
    check("t2_pulse",  page_wrap_pulse,  32'h1);
    check("t2_status", page_wrap_status, 32'h4);
    check("t2_addr",   dma_address,      32'hA0034);
    tick();
    check("t2_pulse_end", page_wrap_pulse,  32'h0);
    check("t2_status_hold", page_wrap_status, 32'h4);
    page_write(2'd1, 8'h0A);
    check("t2_status_clr", page_wrap_status, 32'h0);

    // Decrement wrap on channel 2 coinciding with a commit to channel 2: set wins
    dma_data_bus   = 8'hFF;
    address_strobe = 1'b1;
    address_in     = 2'd1;
    data_bus_in    = 8'h0A;
    chip_select_n  = 1'b0;
    io_write_n     = 1'b0;
    tick();
    address_strobe = 1'b0;
    io_write_n     = 1'b1;
    chip_select_n  = 1'b1;
    tick();
    check("coincide_pulse",  page_wrap_pulse,  32'h1);
    check("coincide_status", page_wrap_status, 32'h4);
    page_write(2'd1, 8'h0A);
    check("coincide_clr", page_wrap_status, 32'h0);

    // Decrement wrap on channel 3, then channel change to 0 does not flag
    dma_acknowledge = 4'b1000;
    strobe_hi(8'h00);
    check("t3_reload_pulse", page_wrap_pulse, 32'h0);
    strobe_hi(8'hFF);
    check("t3_pulse",  page_wrap_pulse,  32'h1);
    check("t3_status", page_wrap_status, 32'h8);
    check("t3_addr",   dma_address,      32'h3FF34);
    dma_acknowledge = 4'b0001;
    strobe_hi(8'h00);
    check("t3_chg_pulse",  page_wrap_pulse,  32'h0);
    check("t3_chg_status", page_wrap_status, 32'h8);
    check("t3_chg_addr",   dma_address,      32'hC0034);

    // DACK conflict: address holds even though the low byte moves
    dma_acknowledge = 4'b0101;
    dma_address_low = 8'h99;
    #1;
    check("t4_conflict", dack_conflict,     32'h1);
    check("t4_valid",    dma_address_valid, 32'h0);
    tick();
    tick();
    check("t4_addr_hold", dma_address, 32'hC0034);
    address_enable = 1'b0;
    #1;
    check("t4_no_aen_conflict", dack_conflict, 32'h0);

    // Back to a single channel: select held at 0, so the page is ch0's
    address_enable  = 1'b1;
    dma_acknowledge = 4'b0001;
    tick();
    check("t4_resume_addr", dma_address, 32'hC0099);

    // Reset mid-transfer with strobe high
    dma_acknowledge = 4'b0010;
    dma_address_low = 8'h34;
    dma_data_bus    = 8'h55;
    address_strobe  = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("t5_addr",     dma_address,       32'h0);
    check("t5_valid",    dma_address_valid, 32'h0);
    check("t5_status",   page_wrap_status,  32'h0);
    check("t5_pulse",    page_wrap_pulse,   32'h0);
    check("t5_conflict", dack_conflict,     32'h0);
    address_strobe = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("t5_post_addr", dma_address, 32'h00034);

    // First strobe after reset (00 -> FF on channel 0) must not flag
    dma_acknowledge = 4'b0001;
    strobe_hi(8'hFF);
    check("t5_first_pulse",  page_wrap_pulse,  32'h0);
    check("t5_first_status", page_wrap_status, 32'h0);

    // CPU read-back
    page_write(2'd2, 8'h07);
    address_in    = 2'd2;
    chip_select_n = 1'b0;
    io_read_n     = 1'b0;
    #1;
`ifdef DMA_PAGE_READBACK_EN
    check("t6_readback", data_bus_out, 32'h07);
`else
    check("t6_readback", data_bus_out, 32'h00);
`endif
    chip_select_n = 1'b1;
    #1;
    check("t6_no_cs", data_bus_out, 32'h00);
    io_read_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
